// File: rtl/reg_stat_multi.sv
// Multi-issue register status file: data plus producer tag per register,
// with writeback-by-tag, same-cycle bypass, intra-bundle rename forwarding and flush.

// One combinational source lookup: imm/x0/forward/bypass/stored priority chain.
module reg_stat_multi_src #(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 4,
  parameter int AW       = 5,
  parameter int ISSUE    = 2,
  parameter int WB_PORTS = 3
)(
  input  logic                              en,
  input  logic [AW-1:0]                     addr,
  input  logic [XLEN-1:0]                   imm,
  input  logic [XLEN-1:0]                   st_data,
  input  logic [TAG_W-1:0]                  st_tag,
  input  logic [ISSUE-1:0]                  fwd_en,
  input  logic [ISSUE-1:0][AW-1:0]          ren_addr,
  input  logic [ISSUE-1:0][TAG_W-1:0]       ren_tag,
  input  logic [WB_PORTS-1:0]               wb_en,
  input  logic [WB_PORTS-1:0][AW-1:0]       wb_addr,
  input  logic [WB_PORTS-1:0][TAG_W-1:0]    wb_tag,
  input  logic [WB_PORTS-1:0][XLEN-1:0]     wb_data,
  output logic [XLEN-1:0]                   data,
  output logic [TAG_W-1:0]                  tag
);
  logic              fwd, byp;
  logic [TAG_W-1:0]  fwd_tag;
  logic [XLEN-1:0]   byp_data;

  always_comb begin
    fwd      = 1'b0;
    fwd_tag  = '0;
    // ascending scan: the highest earlier slot wins
    for (int j = 0; j < ISSUE; j++)
      if (fwd_en[j] && ren_addr[j] == addr) begin
        fwd     = 1'b1;
        fwd_tag = ren_tag[j];
      end
    byp      = 1'b0;
    byp_data = '0;
    // descending scan: the lowest matching port wins
    for (int p = WB_PORTS-1; p >= 0; p--)
      if (wb_en[p] && wb_addr[p] == addr && wb_tag[p] == st_tag) begin
        byp      = 1'b1;
        byp_data = wb_data[p];
      end
    data = st_data;
    tag  = st_tag;
    if (!en) begin
      data = imm;
      tag  = '0;
    end else if (addr == '0) begin
      data = '0;
      tag  = '0;
    end else if (fwd) begin
      tag  = fwd_tag;
    end else if (st_tag != '0 && byp) begin
      data = byp_data;
      tag  = '0;
    end
  end
endmodule

module reg_stat_multi #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32,
  parameter int TAG_W     = 4,
  parameter int ISSUE     = 2,
  parameter int WB_PORTS  = 3,
  localparam int AW       = $clog2(REG_COUNT)
)(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rdy,
  input  logic                              flush,
  input  logic [2*ISSUE-1:0]                rd_en,
  input  logic [2*ISSUE-1:0][AW-1:0]        rd_addr,
  input  logic [ISSUE-1:0][XLEN-1:0]        imm,
  output logic [2*ISSUE-1:0][XLEN-1:0]      rd_data,
  output logic [2*ISSUE-1:0][TAG_W-1:0]     rd_tag,
  input  logic [ISSUE-1:0]                  ren_en,
  input  logic [ISSUE-1:0][AW-1:0]          ren_addr,
  input  logic [ISSUE-1:0][TAG_W-1:0]       ren_tag,
  output logic [ISSUE-1:0][TAG_W-1:0]       ren_old_tag,
  input  logic [WB_PORTS-1:0]               wb_en,
  input  logic [WB_PORTS-1:0][AW-1:0]       wb_addr,
  input  logic [WB_PORTS-1:0][TAG_W-1:0]    wb_tag,
  input  logic [WB_PORTS-1:0][XLEN-1:0]     wb_data
);
  logic [REG_COUNT-1:0][XLEN-1:0]  data_q, data_d;
  logic [REG_COUNT-1:0][TAG_W-1:0] tag_q,  tag_d;
  logic [ISSUE-1:0][XLEN-1:0]      old_data_unused;

  for (genvar i = 0; i < 2*ISSUE; i++) begin : g_src
    localparam logic [ISSUE-1:0] FWD = ISSUE'((1 << (i/2)) - 1);
    reg_stat_multi_src #(.XLEN(XLEN), .TAG_W(TAG_W), .AW(AW), .ISSUE(ISSUE), .WB_PORTS(WB_PORTS)) u_src (
      .en(rd_en[i]), .addr(rd_addr[i]), .imm(imm[i/2]),
      .st_data(data_q[rd_addr[i]]), .st_tag(tag_q[rd_addr[i]]),
      .fwd_en(ren_en & FWD), .ren_addr(ren_addr), .ren_tag(ren_tag),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_tag(wb_tag), .wb_data(wb_data),
      .data(rd_data[i]), .tag(rd_tag[i])
    );
  end

  // Old-tag lookup shares the read chain so in-flight writebacks report 0.
  for (genvar s = 0; s < ISSUE; s++) begin : g_ren
    localparam logic [ISSUE-1:0] FWD = ISSUE'((1 << s) - 1);
    reg_stat_multi_src #(.XLEN(XLEN), .TAG_W(TAG_W), .AW(AW), .ISSUE(ISSUE), .WB_PORTS(WB_PORTS)) u_old (
      .en(ren_en[s]), .addr(ren_addr[s]), .imm('0),
      .st_data(data_q[ren_addr[s]]), .st_tag(tag_q[ren_addr[s]]),
      .fwd_en(ren_en & FWD), .ren_addr(ren_addr), .ren_tag(ren_tag),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_tag(wb_tag), .wb_data(wb_data),
      .data(old_data_unused[s]), .tag(ren_old_tag[s])
    );
  end

  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    if (flush) begin
      tag_d = '0;
    end else begin
      for (int p = WB_PORTS-1; p >= 0; p--)
        if (wb_en[p] && wb_addr[p] != '0 && wb_tag[p] == tag_q[wb_addr[p]]) begin
          data_d[wb_addr[p]] = wb_data[p];
          tag_d[wb_addr[p]]  = '0;
        end
      // renames applied last so a new tag beats a same-cycle writeback clear
      for (int s = 0; s < ISSUE; s++)
        if (ren_en[s] && ren_addr[s] != '0)
          tag_d[ren_addr[s]] = ren_tag[s];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      tag_q  <= '0;
    end else if (rdy) begin
      data_q <= data_d;
      tag_q  <= tag_d;
    end
  end
endmodule

// File: tb/tb_reg_stat_multi.sv
// Table-driven bench for reg_stat_multi; expected outputs queued at drive time, popped at sample time.
module tb_reg_stat_multi;
  logic clk = 1'b0, rst = 1'b0, rdy, flush;
  logic [3:0]        rd_en;
  logic [3:0][4:0]   rd_addr;
  logic [1:0][31:0]  imm;
  logic [3:0][31:0]  rd_data;
  logic [3:0][3:0]   rd_tag;
  logic [1:0]        ren_en;
  logic [1:0][4:0]   ren_addr;
  logic [1:0][3:0]   ren_tag, ren_old_tag;
  logic [2:0]        wb_en;
  logic [2:0][4:0]   wb_addr;
  logic [2:0][3:0]   wb_tag;
  logic [2:0][31:0]  wb_data;

  always #5 clk = ~clk;

  reg_stat_multi dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .rd_en(rd_en), .rd_addr(rd_addr), .imm(imm), .rd_data(rd_data), .rd_tag(rd_tag),
    .ren_en(ren_en), .ren_addr(ren_addr), .ren_tag(ren_tag), .ren_old_tag(ren_old_tag),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_tag(wb_tag), .wb_data(wb_data)
  );

  typedef struct packed {
    logic [3:0][31:0] d;
    logic [3:0][3:0]  t;
    logic [1:0][3:0]  o;
  } exp_t;

  typedef struct packed {
    logic rdy, flush;
    logic [3:0] rd_en; logic [3:0][4:0] rd_addr; logic [1:0][31:0] imm;
    logic [1:0] ren_en; logic [1:0][4:0] ren_addr; logic [1:0][3:0] ren_tag;
    logic [2:0] wb_en; logic [2:0][4:0] wb_addr; logic [2:0][3:0] wb_tag; logic [2:0][31:0] wb_data;
    exp_t e;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   errors = 0, checks = 0;

  function automatic vec_t nv();
    vec_t v = '0;
    v.rdy = 1'b1;
    v.imm[0] = 32'h1234; v.imm[1] = 32'h5678;
    v.e.d[0] = 32'h1234; v.e.d[1] = 32'h1234;
    v.e.d[2] = 32'h5678; v.e.d[3] = 32'h5678;
    return v;
  endfunction

  function automatic vec_t rd(vec_t v, int s, logic [4:0] a, logic [31:0] d, logic [3:0] t);
    v.rd_en[s] = 1'b1; v.rd_addr[s] = a; v.e.d[s] = d; v.e.t[s] = t;
    return v;
  endfunction

  function automatic vec_t rn(vec_t v, int s, logic [4:0] a, logic [3:0] t, logic [3:0] old);
    v.ren_en[s] = 1'b1; v.ren_addr[s] = a; v.ren_tag[s] = t; v.e.o[s] = old;
    return v;
  endfunction

  function automatic vec_t wbk(vec_t v, int p, logic [4:0] a, logic [3:0] t, logic [31:0] d);
    v.wb_en[p] = 1'b1; v.wb_addr[p] = a; v.wb_tag[p] = t; v.wb_data[p] = d;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rdy = v.rdy; flush = v.flush;
    rd_en = v.rd_en; rd_addr = v.rd_addr; imm = v.imm;
    ren_en = v.ren_en; ren_addr = v.ren_addr; ren_tag = v.ren_tag;
    wb_en = v.wb_en; wb_addr = v.wb_addr; wb_tag = v.wb_tag; wb_data = v.wb_data;
    sb.push_back(v.e);
  endtask

  task automatic cmp(input string nm, input int idx, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s[%0d]: got %h want %h", nm, idx, got, want);
    end
  endtask

  task automatic check(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", nm);
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < 4; i++) begin
      cmp({nm, ".data"}, i, rd_data[i], e.d[i]);
      cmp({nm, ".tag"},  i, 32'(rd_tag[i]), 32'(e.t[i]));
    end
    for (int s = 0; s < 2; s++)
      cmp({nm, ".old"}, s, 32'(ren_old_tag[s]), 32'(e.o[s]));
  endtask

  initial begin
    vec_t v;
    // reset-state view and plain read
    tbl.push_back(nv());
    v = nv(); v = rd(v,0,5,0,0); v = rd(v,2,0,0,0); v = rn(v,0,0,5,0); v = wbk(v,0,0,0,32'hFFFF); tbl.push_back(v);
    // rename x5 -> tag 3, bypass, then stored
    v = nv(); v = rn(v,0,5,3,0); v = rd(v,1,5,0,0); v = rd(v,2,5,0,3); v = rd(v,3,0,0,0); tbl.push_back(v);
    v = nv(); v = wbk(v,1,5,3,32'hDEADBEEF); v = rd(v,0,5,32'hDEADBEEF,0); tbl.push_back(v);
    v = nv(); v = rd(v,0,5,32'hDEADBEEF,0); tbl.push_back(v);
    // stale writeback dropped
    v = nv(); v = rn(v,0,7,2,0); tbl.push_back(v);
    v = nv(); v = rn(v,0,7,5,2); v = rd(v,0,7,0,2); tbl.push_back(v);
    v = nv(); v = wbk(v,0,7,2,32'h11); v = rd(v,0,7,0,5); tbl.push_back(v);
    v = nv(); v = wbk(v,2,7,5,32'h22); v = rd(v,3,7,32'h22,0); v = rd(v,0,7,32'h22,0); tbl.push_back(v);
    v = nv(); v = rd(v,0,7,32'h22,0); tbl.push_back(v);
    // intra-bundle forwarding, highest slot wins
    v = nv(); v = rn(v,0,9,4,0); v = rn(v,1,9,6,4); v = rd(v,2,9,0,4); v = rd(v,0,9,0,0); tbl.push_back(v);
    v = nv(); v = rd(v,0,9,0,6); v = rn(v,0,3,1,0); tbl.push_back(v);
    // rename vs writeback same cycle
    v = nv(); v = wbk(v,0,3,1,32'h55); v = rn(v,0,3,7,0); v = rd(v,0,3,32'h55,0); v = rd(v,2,3,0,7); tbl.push_back(v);
    v = nv(); v = rd(v,0,3,32'h55,7); tbl.push_back(v);
    // lowest wb port wins; tag x2/x4/x6 for flush
    v = nv(); v = rn(v,0,2,8,0); v = rn(v,1,4,9,0); tbl.push_back(v);
    v = nv(); v = rn(v,0,6,10,0); v = rn(v,1,4,11,0); v = wbk(v,1,4,9,32'hAA); v = wbk(v,2,4,9,32'hBB);
    v = rd(v,0,4,32'hAA,0); v = rd(v,2,4,32'hAA,0); tbl.push_back(v);
    v = nv(); v.flush = 1'b1; v = wbk(v,0,2,8,32'h99); v = rn(v,0,10,12,0);
    v = rd(v,0,2,32'h99,0); v = rd(v,1,4,32'hAA,11); tbl.push_back(v);
    v = nv(); v = rd(v,0,2,0,0); v = rd(v,1,4,32'hAA,0); v = rd(v,2,6,0,0); v = rd(v,3,10,0,0); tbl.push_back(v);
    // rdy=0 freezes renames and flush
    v = nv(); v.rdy = 1'b0; v = rn(v,0,12,13,0); v = rd(v,0,12,0,0); tbl.push_back(v);
    v = nv(); v = rn(v,0,12,13,0); v = rd(v,0,12,0,0); tbl.push_back(v);
    v = nv(); v.rdy = 1'b0; v.flush = 1'b1; v = rd(v,0,12,0,13); tbl.push_back(v);
    v = nv(); v = rd(v,0,12,0,13); v = rd(v,1,5,32'hDEADBEEF,0); tbl.push_back(v);

    for (int k = 0; k < tbl.size(); k++) begin
      @(posedge clk); #1;
      drive(tbl[k]);
      #3 check($sformatf("v%0d", k));
      if (k == 0) rst = 1'b1;
    end

    // asynchronous reset mid-cycle clears state without an edge
    @(posedge clk); #1;
    v = nv(); v = rd(v,0,5,32'hDEADBEEF,0); v = rd(v,1,12,0,13);
    drive(v);
    #2 check("pre_rst");
    rst = 1'b0;
    v.e.d[0] = 32'h0; v.e.t[1] = 4'h0;
    sb.push_back(v.e);
    #1 check("async_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_stat_multi.md
Name: reg_stat_multi

Overview:
- Parametrised successor of the dispatch-stage register status file: architectural register data plus a per-register producer tag.
- Serves ISSUE dispatch slots (two source reads plus one destination rename each) and WB_PORTS writeback buses.
- Writeback retires a tag by matching the producer tag itself, not a fixed per-unit port ID.
- Adds same-cycle writeback bypass on reads, intra-bundle rename forwarding, and a global flush for mispredict recovery.

Parameters:
XLEN, 32, data word width
REG_COUNT, 32, architectural registers; register 0 is hardwired to zero and never tagged
TAG_W, 4, producer tag width; tag value 0 means UNLOCKED
ISSUE, 2, dispatch slots per cycle
WB_PORTS, 3, writeback buses per cycle

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
rdy  in  1  global enable; when 0, no state changes
flush  in  1  clear all tags; drop this cycle's renames and writebacks
rd_en  in  2*ISSUE  source read enable; slot s uses bit 2s (rs1) and bit 2s+1 (rs2)
rd_addr  in  2*ISSUE*log2(REG_COUNT)  source register addresses
imm  in  ISSUE*XLEN  per-slot immediate, returned when the source read is disabled
rd_data  out  2*ISSUE*XLEN  source operand value
rd_tag  out  2*ISSUE*TAG_W  source producer tag; 0 means the value is ready
ren_en  in  ISSUE  destination rename enable
ren_addr  in  ISSUE*log2(REG_COUNT)  destination register
ren_tag  in  ISSUE*TAG_W  new producer tag; never 0
ren_old_tag  out  ISSUE*TAG_W  tag currently held by the destination; 0 if ren_en=0
wb_en  in  WB_PORTS  writeback valid
wb_addr  in  WB_PORTS*log2(REG_COUNT)  writeback register
wb_tag  in  WB_PORTS*TAG_W  producer tag of the result
wb_data  in  WB_PORTS*XLEN  result value

Behaviour:
- Reset (rst=0, asynchronous): all data and tags go to 0. Combinational outputs then read 0, or imm for disabled reads.
- Reads are combinational, evaluated per source in this priority order:
  - rd_en=0: data=imm of the slot, tag=0.
  - addr=0: data=0, tag=0.
  - An earlier slot j<s has ren_en and the same ren_addr: tag=ren_tag of the highest such j; data=stored value.
  - Stored tag is nonzero and some wb port has wb_en, wb_addr==addr and wb_tag==stored tag: data=wb_data of the lowest such port, tag=0 (bypass).
  - Otherwise: stored data and stored tag.
- ren_old_tag uses the same chain, including earlier-slot forwarding and bypass, so a slot renaming a register written this cycle reports 0.
- Sequential update at posedge clk, rdy=1, flush=0:
  - Writeback: for port p, if wb_en, wb_addr!=0 and tag[wb_addr]==wb_tag, then data<=wb_data and tag<=0. Mismatched writebacks are stale and dropped silently. If several ports match the same register, the lowest index wins.
  - Rename: for slot s, if ren_en and ren_addr!=0, then tag<=ren_tag. If several slots rename the same register, the highest slot wins.
  - Rename versus writeback on the same register in the same cycle: data is still written if the old tag matched; the tag takes the new ren_tag and does not clear.
- flush=1 with rdy=1: all tags <=0, data unchanged, renames and writebacks of that cycle ignored. Read outputs in that cycle still follow the normal combinational rules.
- rdy=0: state frozen and flush ignored; combinational outputs remain valid.
- Register 0: never written, never tagged, always reads 0 with tag 0.
- Latency: rename and writeback become visible in stored state one cycle later. Bypass and intra-bundle forwarding make them visible to reads in the same cycle.

Test Plan:
- Reset, then rd_en=0 with imm0=0x1234 -> rd_data=0x1234, rd_tag=0. rd_en=1 on x5 -> data 0, tag 0.
- Rename x5 to tag 3 in slot 0. Next cycle wb port1 {x5, tag3, 0xDEADBEEF} -> a read of x5 that cycle returns 0xDEADBEEF with tag 0 (bypass). The cycle after, stored data is 0xDEADBEEF and tag is 0.
- Rename x7 to tag 2, then rename x7 to tag 5. wb {x7, tag2, 0x11} -> dropped; x7 keeps tag 5 and its old data. wb {x7, tag5, 0x22} -> x7=0x22, tag 0.
- Same cycle: slot 0 renames x9 to tag 4 and slot 1 reads x9 -> slot 1 rd_tag=4. Both slots rename x9 (tags 4 and 6) -> stored tag 6.
- x3 has tag 1; in one cycle wb {x3, tag1, 0x55} and slot 0 renames x3 to tag 7 -> data 0x55, tag 7, ren_old_tag=0.
- Tag x2, x4, x6; assert flush together with wb {x2, matching tag, 0x99} -> all tags 0, x2 data unchanged. Hold rdy=0 with a pending rename -> no change. Assert rst mid-stream -> everything clears immediately without a clock edge.
